// File: rtl/bigmem_arbiter_if.sv
// bigmem_arbiter_if: one requester's access/response bundle into the big-memory arbiter.
interface bigmem_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bigmem_arbiter.sv
// bigmem_arbiter: round-robin, burst-bounded sharing of the single-port big memory between ports A and B.
module bigmem_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  bigmem_arbiter_if.slave   port_a,
  bigmem_arbiter_if.slave   port_b,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d, pt_q, pt_d;
  logic                    stay, pref_b, gnt_a, gnt_b, gnt, out_v, a_rv, b_rv;
  always_comb begin
    // cnt==0 only right after reset, so the first tie falls to A rather than the reset value of last
    stay       = (last_q ? port_b.req : port_a.req) && cnt_q != '0 && cnt_q < CNT_W'(MAX_BURST);
    pref_b     = stay ? last_q : !last_q;
    gnt_b      = !reset && port_b.req && (pref_b || !port_a.req);
    gnt_a      = !reset && port_a.req && (!pref_b || !port_b.req);
    gnt        = gnt_a || gnt_b;
    mem_we_o   = gnt_b ? port_b.we : gnt_a && port_a.we;
    mem_addr_o = gnt_b ? port_b.addr : gnt_a ? port_a.addr : '0;
    mem_din_o  = gnt_b ? port_b.wdata : gnt_a ? port_a.wdata : '0;
    last_d     = gnt ? gnt_b : last_q;
    cnt_d      = !gnt ? cnt_q : gnt_b != last_q ? CNT_W'(1) :
                 cnt_q == CNT_W'(MAX_BURST) ? cnt_q : cnt_q + 1'b1;
    pv_d       = READ_LATENCY'({pv_q, gnt && !mem_we_o});
    pt_d       = READ_LATENCY'({pt_q, gnt_b});
    out_v      = !reset && pv_q[READ_LATENCY-1];
    a_rv       = out_v && !pt_q[READ_LATENCY-1];
    b_rv       = out_v && pt_q[READ_LATENCY-1];
    mem_oe_o   = out_v;
    port_a.gnt    = gnt_a;
    port_b.gnt    = gnt_b;
    port_a.rvalid = a_rv;
    port_b.rvalid = b_rv;
    port_a.rdata  = a_rv ? mem_dout_i : '0;
    port_b.rdata  = b_rv ? mem_dout_i : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      cnt_q  <= '0;
      pv_q   <= '0;
      pt_q   <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      pv_q   <= pv_d;
      pt_q   <= pt_d;
    end
  end
endmodule
